dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the MEM-stage load/store interface.
- Accepts one read or write request per transaction over a valid/ready handshake.
- Returns a single-cycle response pulse after a fixed, parameterised latency.
- Exports busy so the pipeline hazard logic can freeze IF/ID/EX while an access is outstanding.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, byte-address width from the CPU.
- DEPTH_LOG2, 15, log2 of word count; word index = req_addr[DEPTH_LOG2:1].
- LATENCY, 4, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_wr  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address; bit 0 must be 0.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  DATA_W  load data; valid only with rsp_valid.
- rsp_err  output  1  misaligned-access flag; valid only with rsp_valid.
- busy  output  1  transaction outstanding (state != IDLE).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, req_ready = 1.
  - Array contents are not cleared.
- States: IDLE, BUSY, RESP.
- req_ready = (state == IDLE). It is combinational from state only and never depends on req_valid.
- Accept: req_valid & req_ready at a rising edge (cycle T).
  - Latch req_wr, req_addr, req_wdata.
  - If LATENCY == 1, go to RESP. Otherwise go to BUSY with counter = LATENCY-2.
- BUSY: decrement the counter each edge; when the counter is 0, go to RESP on the next edge.
- On the edge entering RESP (the access edge):
  - Aligned write: the array is written.
  - Aligned read: rsp_rdata is registered from the array.
- RESP, cycle T+LATENCY:
  - rsp_valid = 1 for exactly this cycle.
  - Next edge: return to IDLE, rsp_valid = 0.
  - req_ready returns to 1 at cycle T+LATENCY+1.
- Throughput: one transaction per LATENCY+1 cycles. No overlap or pipelining.
- Write response: rsp_valid pulses as an acknowledge, with rsp_rdata = 0.
- Misaligned access (latched addr[0] = 1):
  - Write is suppressed and the array is unchanged.
  - rsp_rdata = 0, rsp_err = 1 with rsp_valid.
  - Timing is identical to an aligned access.
- rsp_err = 0 for aligned accesses. rsp_rdata holds its value outside rsp_valid, but consumers must ignore it.
- Requests in BUSY or RESP are ignored: req_ready = 0 and the requester holds.
- Read-after-write to the same address in consecutive transactions returns the new data, since accesses are strictly sequential.
- Reset mid-transaction (BUSY or RESP):
  - The transaction is aborted; a pending write is discarded unless the access edge has already occurred.
  - No rsp_valid is produced.
  - req_ready = 1 immediately on rst_n falling.
- busy = 1 in BUSY and RESP.
- Address bits above DEPTH_LOG2 are ignored, so addresses alias.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum dmem_state_t {IDLE, BUSY, RESP};
  - DMEM_LATENCY_DEFAULT = 4;
  - DATA_W = 16.
- Natural sub-module: dmem_array, a single-port synchronous RAM, 2**DEPTH_LOG2 x DATA_W, with one write enable and registered read. It has no reset and supports optional $readmemh init.

Test Plan:
- Reset then idle -> req_ready = 1, rsp_valid = 0, busy = 0, rsp_rdata = 0000.
- Write A = 0x0010, D = 0xBEEF accepted at T, LATENCY = 4 -> rsp_valid only at T+4, rsp_err = 0, rsp_rdata = 0000, req_ready = 0 for T+1..T+4, busy = 1.
- Read A = 0x0010 immediately after -> rsp_valid at T'+4 with rsp_rdata = BEEF.
- Misaligned write A = 0x0011, D = 0x1234, then read 0x0010 -> first response rsp_err = 1; read returns BEEF, unchanged.
- req_valid held high continuously with alternating writes/reads, LATENCY = 1 -> acceptance every 2 cycles, each rsp_valid exactly 1 cycle after accept.
- rst_n pulsed low at T+2 of a write to 0x0020 with D = 0x5555, then read 0x0020 -> no rsp_valid for the aborted write, and the read returns the prior contents of 0x0020.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data-memory responder and its RAM.
package cpu_pkg;

    localparam int DATA_W               = 16;
    localparam int DMEM_LATENCY_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM, 2**DEPTH_LOG2 words of DATA_W bits.
// One write enable, registered read port, no reset on contents or read data.
module dmem_array #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_r [0:(2**DEPTH_LOG2)-1];
    logic [DATA_W-1:0] rdata_r;

    // Enabled access: store on we, otherwise capture the addressed word
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= wdata;
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Target end of the MEM-stage load/store interface. One transaction at a
// time; the RAM is touched on the edge entering RESP and a one-cycle
// response strobe follows LATENCY cycles after acceptance.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 15,
    parameter int LATENCY    = DMEM_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    // BUSY counts down from LATENCY-2 so that RESP is entered LATENCY-1
    // edges after the accept edge; LATENCY==1 skips BUSY altogether.
    localparam logic [3:0] CNT_INIT     = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic       SINGLE_CYCLE = (LATENCY == 1) ? 1'b1 : 1'b0;

    dmem_state_t state_r;
    dmem_state_t state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;

    logic              wr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic              accept_s;
    logic              access_s;
    logic              acc_wr_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_wdata_s;

    logic              ram_en_s;
    logic [DATA_W-1:0] ram_rdata_s;

    logic rsp_valid_r;
    logic rsp_err_r;
    logic rd_sel_r;

    assign accept_s = req_valid & (state_r == IDLE);

    // State register and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (SINGLE_CYCLE) begin
                        state_nxt_s = RESP;
                    end else begin
                        state_nxt_s = BUSY;
                        cnt_nxt_s   = CNT_INIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State decode: handshake, busy flag and the access-edge strobe
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        access_s  = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                access_s  = req_valid & SINGLE_CYCLE;
            end
            BUSY: begin
                busy     = 1'b1;
                access_s = (cnt_r == 4'd0);
            end
            RESP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Request fields come straight from the port on a single-cycle accept,
    // otherwise from the copy latched at acceptance
    always_comb begin
        if (state_r == IDLE) begin
            acc_wr_s    = req_wr;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
        end else begin
            acc_wr_s    = wr_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
    end

    // Latch the request on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            wr_r    <= req_wr;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end
    end

    // Misaligned accesses never reach the RAM; reset also blocks it
    assign ram_en_s = access_s & ~acc_addr_s[0] & rst_n;

    dmem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (acc_wr_s),
        .addr  (acc_addr_s[DEPTH_LOG2:1]),
        .wdata (acc_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Response strobe, error flag and read-data select, all set on the access edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rd_sel_r    <= 1'b0;
        end else begin
            rsp_valid_r <= access_s;
            if (access_s) begin
                rsp_err_r <= acc_addr_s[0];
                rd_sel_r  <= ~acc_wr_s & ~acc_addr_s[0];
            end
        end
    end

    // The RAM read register holds between reads, so gating it keeps
    // rsp_rdata stable and zero after writes, misaligned accesses and reset
    assign rsp_rdata = rd_sel_r ? ram_rdata_s : {DATA_W{1'b0}};
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 uses LATENCY=4,
// instance 1 uses LATENCY=1. A word-indexed reference memory predicts
// every response; a negedge monitor compares timing, data and flags.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int NI   = 2;
    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    typedef struct {
        logic [15:0] rdata;
        bit          known;
        bit          err;
        int          cyc_at;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NI-1:0] req_valid;
    logic [NI-1:0] req_wr;
    logic [15:0]   req_addr  [NI];
    logic [15:0]   req_wdata [NI];
    wire  [NI-1:0] rdy_w;
    wire  [NI-1:0] vld_w;
    wire  [NI-1:0] err_w;
    wire  [NI-1:0] busy_w;
    wire  [15:0]   rdata_w   [NI];

    int cyc   = 0;
    int n_vec = 0;
    int n_mis = 0;
    int acc_cnt  [NI];
    int rsp_cnt  [NI];
    int last_acc [NI];

    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] m0 [int];
    logic [15:0] m1 [int];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.LATENCY(LAT0)) dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(rdy_w[0]), .req_wr(req_wr[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(vld_w[0]), .rsp_rdata(rdata_w[0]), .rsp_err(err_w[0]),
        .busy(busy_w[0])
    );

    dmem_responder #(.LATENCY(LAT1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(rdy_w[1]), .req_wr(req_wr[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(vld_w[1]), .rsp_rdata(rdata_w[1]), .rsp_err(err_w[1]),
        .busy(busy_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void q_push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic exp_t q_pop(input int i);
        exp_t e;
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        return e;
    endfunction

    // Reference: memory of words indexed by byte address / 2; odd addresses
    // flag an error and leave memory alone; writes answer with zero data.
    function automatic exp_t model_access(input int i, input bit wr,
                                          input logic [15:0] addr, input logic [15:0] wd);
        exp_t e;
        int   idx;
        idx      = int'(addr) / 2;
        e.rdata  = 16'h0000;
        e.known  = 1'b1;
        e.err    = addr[0];
        e.cyc_at = 0;
        if (addr[0] == 1'b0) begin
            if (wr) begin
                if (i == 0) m0[idx] = wd;
                else        m1[idx] = wd;
            end else if (i == 0) begin
                if (m0.exists(idx)) e.rdata = m0[idx];
                else                e.known = 1'b0;
            end else begin
                if (m1.exists(idx)) e.rdata = m1[idx];
                else                e.known = 1'b0;
            end
        end
        return e;
    endfunction

    // Present one request and wait for it to be taken; hold keeps req_valid high afterwards
    task automatic issue(input int i, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wd, input bit hold);
        exp_t e;
        int   waited;
        int   acc;
        waited = 0;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_wr[i]    = wr;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        while (rdy_w[i] !== 1'b1) begin
            waited++;
            if (waited > 64) begin
                chk("accept_timeout", 32'(waited), 32'd0);
                req_valid[i] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        acc = cyc + 1;
        if (hold && last_acc[i] >= 0) chk("accept_spacing", 32'(acc - last_acc[i]), 32'(lat(i) + 1));
        last_acc[i] = acc;
        e        = model_access(i, wr, addr, wd);
        e.cyc_at = acc + lat(i) - 1;
        q_push(i, e);
        @(posedge clk);
        acc_cnt[i]++;
        if (!hold) begin
            #1 req_valid[i] = 1'b0;
        end
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (acc_cnt[i] != rsp_cnt[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(acc_cnt[i] - rsp_cnt[i]), 32'd0);
    endtask

    // Monitor: busy/ready against outstanding count, pop and compare every response
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_n) begin
                chk($sformatf("busy%0d", i), {31'd0, busy_w[i]}, {31'd0, acc_cnt[i] != rsp_cnt[i]});
                chk($sformatf("ready%0d", i), {31'd0, rdy_w[i]}, {31'd0, acc_cnt[i] == rsp_cnt[i]});
                if (vld_w[i]) begin
                    if (q_size(i) == 0) begin
                        chk($sformatf("unexpected_rsp%0d", i), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q_pop(i);
                        chk($sformatf("rsp_cycle%0d", i), 32'(cyc), 32'(e.cyc_at));
                        chk($sformatf("rsp_err%0d", i), {31'd0, err_w[i]}, {31'd0, e.err});
                        if (e.known) chk($sformatf("rsp_rdata%0d", i), {16'd0, rdata_w[i]}, {16'd0, e.rdata});
                        rsp_cnt[i]++;
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        bit          w;
        for (int i = 0; i < NI; i++) begin
            acc_cnt[i]   = 0;
            rsp_cnt[i]   = 0;
            last_acc[i]  = -1;
            req_valid[i] = 1'b0;
            req_wr[i]    = 1'b0;
            req_addr[i]  = 16'h0000;
            req_wdata[i] = 16'h0000;
        end

        // Reset values
        #12;
        for (int i = 0; i < NI; i++) begin
            chk("rst_ready", {31'd0, rdy_w[i]}, 32'd1);
            chk("rst_valid", {31'd0, vld_w[i]}, 32'd0);
            chk("rst_busy",  {31'd0, busy_w[i]}, 32'd0);
            chk("rst_rdata", {16'd0, rdata_w[i]}, 32'd0);
            chk("rst_err",   {31'd0, err_w[i]}, 32'd0);
        end
        #11 rst_n = 1'b1;

        // Directed LATENCY=4 sequence
        issue(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0); drain(0);
        issue(0, 1'b0, 16'h0010, 16'h0000, 1'b0); drain(0);
        issue(0, 1'b1, 16'h0011, 16'h1234, 1'b0); drain(0);
        issue(0, 1'b0, 16'h0010, 16'h0000, 1'b0); drain(0);
        issue(0, 1'b0, 16'h0013, 16'h0000, 1'b0); drain(0);
        issue(0, 1'b1, 16'hFFFE, 16'hA5C3, 1'b0); drain(0);
        issue(0, 1'b0, 16'hFFFE, 16'h0000, 1'b0); drain(0);

        // Random LATENCY=4 traffic over a small address pool
        for (int k = 0; k < 30; k++) begin
            a = 16'h0100 + 16'(2 * $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
            w = ($urandom_range(0, 1) == 1);
            issue(0, w, a, 16'($urandom), 1'b0);
            drain(0);
        end

        // LATENCY=1 with req_valid held high: alternating write/read pairs
        last_acc[1] = -1;
        for (int k = 0; k < 10; k++) begin
            a = 16'h0200 + 16'(2 * $urandom_range(0, 15));
            issue(1, 1'b1, a, 16'($urandom), 1'b1);
            issue(1, 1'b0, a, 16'h0000, 1'b1);
        end
        #1 req_valid[1] = 1'b0;
        drain(1);

        // Reset in the middle of a LATENCY=4 write
        issue(0, 1'b1, 16'h0020, 16'h1111, 1'b0); drain(0);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b1;
        req_addr[0]  = 16'h0020;
        req_wdata[0] = 16'h5555;
        chk("abort_ready_pre", {31'd0, rdy_w[0]}, 32'd1);
        @(posedge clk);
        acc_cnt[0]++;
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, rdy_w[0]}, 32'd1);
        chk("abort_busy",  {31'd0, busy_w[0]}, 32'd0);
        chk("abort_valid", {31'd0, vld_w[0]}, 32'd0);
        acc_cnt[0]--;
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(0, 1'b0, 16'h0020, 16'h0000, 1'b0); drain(0);

        repeat (10) @(negedge clk);
        chk("sb_empty0", 32'(q0.size()), 32'd0);
        chk("sb_empty1", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
